// File: rtl/player_pkg.sv
// Shared types and constants for the music player playback path.
package player_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PLAY,
        ST_PAUSE,
        ST_GAP
    } state_e;

    localparam logic [1:0] LOOP_STOP  = 2'd0;
    localparam logic [1:0] LOOP_TRACK = 2'd1;
    localparam logic [1:0] LOOP_ALL   = 2'd2;

    // Beats per track; element [0] belongs to track 0.
    localparam logic [3:0][7:0] TRACK_LEN = {8'd96, 8'd32, 8'd128, 8'd64};

endpackage

// File: rtl/beat_divider.sv
// Tempo divider: counts 0..TICK_DIV-1 while enabled, pulses tick on the terminal count.
module beat_divider #(
    parameter int unsigned TICK_DIV = 12_500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Tick must not depend on clr: clr is itself derived from tick in the sequencer.
    assign tick = en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/track_sequencer.sv
// Playback scheduler: button handling, beat/track counters and end-of-track sequencing.
module track_sequencer
    import player_pkg::*;
#(
    parameter int unsigned NUM_TRACKS = 4,
    parameter int unsigned TICK_DIV   = 12_500_000,
    parameter int unsigned GAP_BEATS  = 2,
    parameter logic [NUM_TRACKS-1:0][7:0] TRACK_LENS = TRACK_LEN
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          play_btn,
    input  logic                          stop_btn,
    input  logic                          next_btn,
    input  logic                          prev_btn,
    input  logic [1:0]                    loop_mode,
    output logic [$clog2(NUM_TRACKS)-1:0] track,
    output logic [7:0]                    ibeat,
    output logic                          playing,
    output logic                          beat_tick,
    output logic                          track_done
);

    localparam int unsigned TW = $clog2(NUM_TRACKS);
    localparam logic [TW-1:0] LAST_TRACK = TW'(NUM_TRACKS - 1);
    localparam logic [3:0] GAP_LAST = (GAP_BEATS == 0) ? 4'd0 : 4'(GAP_BEATS - 1);

    state_e        state_q, state_d;
    logic [TW-1:0] track_q, track_d;
    logic [7:0]    ibeat_q, ibeat_d;
    logic [3:0]    gap_q, gap_d;
    logic          playing_q, beat_tick_q, beat_tick_d, track_done_q, track_done_d;

    logic          tick, div_en, div_clr;
    logic [TW-1:0] track_inc, track_dec;
    logic [7:0]    cur_len;

    assign track_inc = (track_q == LAST_TRACK) ? '0 : track_q + 1'b1;
    assign track_dec = (track_q == '0) ? LAST_TRACK : track_q - 1'b1;
    assign cur_len   = TRACK_LENS[track_q];
    assign div_en    = (state_q == ST_PLAY) || (state_q == ST_GAP);

    beat_divider #(
        .TICK_DIV (TICK_DIV)
    ) u_div (
        .clk  (clk),
        .rst  (rst),
        .en   (div_en),
        .clr  (div_clr || (state_q == ST_IDLE)),
        .tick (tick)
    );

    always_comb begin
        state_d      = state_q;
        track_d      = track_q;
        ibeat_d      = ibeat_q;
        gap_d        = gap_q;
        beat_tick_d  = 1'b0;
        track_done_d = 1'b0;
        div_clr      = 1'b0;

        if (stop_btn) begin
            state_d = ST_IDLE;
            ibeat_d = '0;
        end else if (play_btn && (state_q != ST_GAP)) begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_PLAY;
                    ibeat_d = '0;
                    div_clr = 1'b1;
                end
                ST_PLAY:  state_d = ST_PAUSE;
                ST_PAUSE: state_d = ST_PLAY;
                default:  state_d = state_q;
            endcase
        end else if (next_btn || prev_btn) begin
            ibeat_d = '0;
            div_clr = 1'b1;
            if (next_btn) begin
                track_d = track_inc;
            end else if (ibeat_q < 8'd2) begin
                track_d = track_dec;
            end
            if (state_q == ST_GAP) begin
                state_d = ST_PLAY;
            end
        end else if (tick) begin
            if (state_q == ST_PLAY) begin
                beat_tick_d = 1'b1;
                if (ibeat_q == cur_len - 8'd1) begin
                    track_done_d = 1'b1;
                    ibeat_d      = '0;
                    if (loop_mode != LOOP_TRACK) begin
                        if ((loop_mode != LOOP_ALL) && (track_q == LAST_TRACK)) begin
                            state_d = ST_IDLE;
                        end else if (GAP_BEATS == 0) begin
                            state_d = ST_PLAY;
                            track_d = track_inc;
                            div_clr = 1'b1;
                        end else begin
                            state_d = ST_GAP;
                            gap_d   = '0;
                        end
                    end
                end else begin
                    ibeat_d = ibeat_q + 8'd1;
                end
            end else if (state_q == ST_GAP) begin
                if (gap_q == GAP_LAST) begin
                    state_d = ST_PLAY;
                    track_d = track_inc;
                    ibeat_d = '0;
                    gap_d   = '0;
                    div_clr = 1'b1;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            track_q      <= '0;
            ibeat_q      <= '0;
            gap_q        <= '0;
            playing_q    <= 1'b0;
            beat_tick_q  <= 1'b0;
            track_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            track_q      <= track_d;
            ibeat_q      <= ibeat_d;
            gap_q        <= gap_d;
            playing_q    <= (state_d == ST_PLAY);
            beat_tick_q  <= beat_tick_d;
            track_done_q <= track_done_d;
        end
    end

    assign track      = track_q;
    assign ibeat      = ibeat_q;
    assign playing    = playing_q;
    assign beat_tick  = beat_tick_q;
    assign track_done = track_done_q;

endmodule
